// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: line levels, tx state encoding and
// default frame geometry used by both the transmitter and the receiver.
package serial_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/serial_tx_if.sv
// Byte-source side of the serial transmitter: enable tick, load handshake,
// parallel data in, and the line/status outputs.
interface serial_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 en;
  logic                 load;
  logic [DATA_BITS-1:0] data_in;
  logic                 tx_out;
  logic                 busy;
  logic                 done;

  modport master (output en, load, data_in, input tx_out, busy, done);
  modport slave  (input en, load, data_in, output tx_out, busy, done);
endinterface

// File: rtl/serial_tx_tick_counter.sv
// Modulo-OVERSAMPLE sample counter; bit_end marks the en-cycle on which the
// count wraps, i.e. the last enabled cycle of the current bit.
module tx_tick_counter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = en && !clr && (cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= bit_end ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/serial_tx.sv
// 8N1 serial transmitter: start bit, DATA_BITS data bits LSB-first, stop bit,
// each held OVERSAMPLE en-cycles. Define PARITY_EN to add an even-parity bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic     clk,
  input  logic     rst,
  serial_tx_if.slave bus
);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_e            state_q, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [IW-1:0]        idx_q, idx_n;
  logic                 tx_q, tx_n;
  logic                 bit_end;
`ifdef PARITY_EN
  logic                 par_q, par_n;
`endif

  // Counter is held clear while idle so every frame starts on a fresh bit.
  tx_tick_counter #(.OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .clr    (state_q == IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      tx_q    <= tx_n;
`ifdef PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    idx_n   = idx_q;
`ifdef PARITY_EN
    par_n   = par_q;
`endif
    case (state_q)
      IDLE: if (bus.load) begin
        shift_n = bus.data_in;
        state_n = START;
`ifdef PARITY_EN
        par_n   = ^bus.data_in;
`endif
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift_q >> 1;
        if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    case (state_n)
      START:   tx_n = START_LEVEL;
      DATA:    tx_n = shift_n[0];
`ifdef PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      STOP:    tx_n = STOP_LEVEL;
      default: tx_n = IDLE_LEVEL;
    endcase
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == STOP) && bit_end;
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: reset/idle, single frames, back-to-back,
// ignored mid-frame load, slow enable with mid-frame reset, and parity frames.
module tb_serial_tx;
  localparam int OS = 16;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * OS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_tx_if #(.DATA_BITS(8)) bus ();
  serial_tx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_run  = 0;
  int   n_fail = 0;
  logic tx_s   [0:1023];
  logic busy_s [0:1023];
  logic done_s [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level of frame bit b (0 = start bit).
  function automatic logic fbit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Issue a load; returns just after the accepting edge (sample 0 follows).
  task automatic start(input logic [7:0] d);
    bus.data_in = d;
    bus.load    = 1'b1;
    bus.en      = 1'b1;
    @(posedge clk); #1;
    bus.load    = 1'b0;
  endtask

  // Run ncyc cycles recording outputs; en high 1 in per cycles; optional
  // load pulse at ld_cyc and reset at rst_cyc. data_in churns otherwise.
  task automatic run(input int ncyc, input int per, input int ld_cyc,
                     input logic [7:0] ld_d, input int rst_cyc);
    for (int k = 0; k < ncyc; k++) begin
      bus.en      = ((k % per) == per - 1);
      bus.load    = (k == ld_cyc);
      bus.data_in = (k == ld_cyc) ? ld_d : 8'(k * 37);
      rst         = (k == rst_cyc);
      @(negedge clk);
      tx_s[k]   = bus.tx_out;
      busy_s[k] = bus.busy;
      done_s[k] = bus.done;
      @(posedge clk); #1;
    end
    bus.load = 1'b0;
    rst      = 1'b0;
    bus.en   = 1'b1;
  endtask

  // Every sample of each bit window must hold the expected level.
  task automatic chk_frame(input string tag, input logic [7:0] d, input int base,
                           input int per, input int nbits, input int last_len);
    for (int b = 0; b < nbits; b++) begin
      logic e, o;
      int   len;
      e   = fbit(d, b);
      o   = e;
      len = (b == nbits - 1 && last_len > 0) ? last_len : OS * per;
      for (int s = 0; s < len; s++)
        if (tx_s[base + b*OS*per + s] !== e) o = tx_s[base + b*OS*per + s];
      chk($sformatf("%s bit%0d", tag, b), 32'(o), 32'(e));
    end
  endtask

  task automatic chk_done(input string tag, input int ncyc, input int exp_cnt, input int exp_at);
    int cnt, at;
    cnt = 0; at = -1;
    for (int k = 0; k < ncyc; k++) if (done_s[k] === 1'b1) begin cnt++; if (at < 0) at = k; end
    chk({tag, " done_cnt"}, 32'(cnt), 32'(exp_cnt));
    if (exp_cnt > 0) chk({tag, " done_at"}, 32'(at), 32'(exp_at));
  endtask

  initial begin
    int bad;
    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx", 32'(bus.tx_out), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    rst = 1'b0; bus.en = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("idle50 bad", 32'(bad), 32'd0);

    // Single frame 0xA5
    start(8'hA5);
    run(FL + 4, 1, -1, 8'h00, -1);
    chk_frame("a5", 8'hA5, 0, 1, NB, 0);
    chk_done("a5", FL + 4, 1, FL - 1);
    chk("a5 busy0", 32'(busy_s[0]), 32'd1);
    chk("a5 busy_last", 32'(busy_s[FL-1]), 32'd1);
    chk("a5 busy_after", 32'(busy_s[FL]), 32'd0);
    chk("a5 tx_after", 32'(tx_s[FL]), 32'd1);

    // Back-to-back: second load in the first busy=0 cycle
    start(8'h00);
    run(2*FL + 4, 1, FL, 8'hFF, -1);
    chk_frame("b2b00", 8'h00, 0, 1, NB, 0);
    chk("b2b gap", 32'(tx_s[FL]), 32'd1);
    chk_frame("b2bff", 8'hFF, FL + 1, 1, NB, 0);
    chk_done("b2b", 2*FL + 4, 2, FL - 1);
    chk("b2b done2", 32'(done_s[2*FL]), 32'd1);

    // Load while busy is ignored
    start(8'h81);
    run(FL + 4, 1, 40, 8'h3C, -1);
    chk_frame("ign81", 8'h81, 0, 1, NB, 0);
    chk_done("ign", FL + 4, 1, FL - 1);
    chk("ign idle", 32'(busy_s[FL+2]), 32'd0);

    // en 1-of-4: 64 clocks per bit, reset during bit 3 aborts silently
    start(8'h55);
    run(210, 4, -1, 8'h00, 200);
    chk_frame("slow55", 8'h55, 0, 4, 4, 9);
    chk("slow rst tx", 32'(tx_s[201]), 32'd1);
    chk("slow rst busy", 32'(busy_s[201]), 32'd0);
    chk_done("slow", 210, 0, 0);

`ifdef PARITY_EN
    start(8'h07);
    run(FL + 4, 1, -1, 8'h00, -1);
    chk_frame("par07", 8'h07, 0, 1, NB, 0);
    chk("par07 pbit", 32'(tx_s[9*OS + 8]), 32'd1);
    chk_done("par07", FL + 4, 1, 175);
    start(8'h03);
    run(FL + 4, 1, -1, 8'h00, -1);
    chk_frame("par03", 8'h03, 0, 1, NB, 0);
    chk("par03 pbit", 32'(tx_s[9*OS + 8]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
